if_fetch_stage: RTL

//  Instruction-fetch stage of the 5-stage RISC-V pipeline: owns the PC register, drives a
//  1-cycle-latency synchronous instruction memory, and loads the IF/ID pipeline register.
//  The PC advances by 4 through the PC_adder incrementer. EX redirects (branch/jump) and

---
 rtl/if_fetch_stage_pkg.sv | 10 +
 rtl/if_fetch_stage_if.sv | 31 +++
 rtl/if_fetch_stage_pc_adder.sv | 14 +
 rtl/if_fetch_stage.sv | 108 ++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: datapath width, NOP encoding, PC step.
// Pure constants; no logic, no latency, no backpressure.
package if_fetch_stage_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam int          PC_STEP      = 4;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, imem request/response, IF/ID register out.
// Combinational wiring only; the stage (master) owns imem_req_o and the id_* outputs.
interface if_fetch_stage_if #(
  parameter int XLEN = 32
);

  logic            stall_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic [31:0]     imem_rdata_i;
  logic            id_valid_o;
  logic [XLEN-1:0] id_pc_o;
  logic [XLEN-1:0] id_pc_plus4_o;
  logic [31:0]     id_instr_o;
  logic            misalign_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
    output imem_req_o, imem_addr_o,
    output id_valid_o, id_pc_o, id_pc_plus4_o, id_instr_o, misalign_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o,
    input  id_valid_o, id_pc_o, id_pc_plus4_o, id_instr_o, misalign_o
  );

endinterface

// File: rtl/if_fetch_stage_pc_adder.sv
// PC incrementer: o_sum = i_a + PC_STEP, wrapping modulo 2^XLEN.
// Purely combinational, zero latency, no backpressure.
module if_fetch_stage_pc_adder
  import if_fetch_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] i_a,
  output logic [XLEN-1:0] o_sum
);

  assign o_sum = i_a + XLEN'(PC_STEP);

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: PC register, 1-cycle sync imem driver, 1-entry skid buffer, IF/ID register.
// Fetch-to-IF/ID latency 2 clocks; stall holds PC and IF/ID, redirect flushes everything in flight.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  if_fetch_stage_if.master bus
);

  logic [XLEN-1:0] r_pc;
  logic            r_resp_vld;
  logic [XLEN-1:0] r_resp_pc;
  logic            r_skid_vld;
  logic [XLEN-1:0] r_skid_pc;
  logic [31:0]     r_skid_instr;
  logic            r_id_vld;
  logic [XLEN-1:0] r_id_pc;
  logic [XLEN-1:0] r_id_pc_plus4;
  logic [31:0]     r_id_instr;
  logic            r_misalign;

  logic            w_issue;
  logic [XLEN-1:0] w_pc_plus4;
  logic            w_cap_vld;
  logic [XLEN-1:0] w_cap_pc;
  logic [31:0]     w_cap_instr;
  logic [XLEN-1:0] w_cap_pc_plus4;
  logic [XLEN-1:0] w_redirect_aligned;

  assign w_issue            = !rst && !bus.stall_i && !bus.redirect_i;
  assign w_redirect_aligned = {bus.redirect_pc_i[XLEN-1:2], 2'b00};

  // A parked skid entry is always older than anything the memory is returning.
  assign w_cap_vld   = r_skid_vld | r_resp_vld;
  assign w_cap_pc    = r_skid_vld ? r_skid_pc    : r_resp_pc;
  assign w_cap_instr = r_skid_vld ? r_skid_instr : bus.imem_rdata_i;

  if_fetch_stage_pc_adder #(.XLEN(XLEN)) u_next_pc_adder (
    .i_a   (r_pc),
    .o_sum (w_pc_plus4)
  );

  if_fetch_stage_pc_adder #(.XLEN(XLEN)) u_link_adder (
    .i_a   (w_cap_pc),
    .o_sum (w_cap_pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_resp_vld    <= 1'b0;
      r_resp_pc     <= '0;
      r_skid_vld    <= 1'b0;
      r_skid_pc     <= '0;
      r_skid_instr  <= NOP_INSTR;
      r_id_vld      <= 1'b0;
      r_id_pc       <= '0;
      r_id_pc_plus4 <= '0;
      r_id_instr    <= NOP_INSTR;
      r_misalign    <= 1'b0;
    end else begin
      r_resp_vld <= w_issue;
      if (w_issue) begin
        r_resp_pc <= r_pc;
      end
      r_misalign <= bus.redirect_i && (|bus.redirect_pc_i[1:0]);

      if (bus.redirect_i) begin
        r_pc       <= w_redirect_aligned;
        r_skid_vld <= 1'b0;
        r_id_vld   <= 1'b0;
        r_id_instr <= NOP_INSTR;
      end else if (bus.stall_i) begin
        if (r_resp_vld) begin
          r_skid_vld   <= 1'b1;
          r_skid_pc    <= r_resp_pc;
          r_skid_instr <= bus.imem_rdata_i;
        end
      end else begin
        r_pc          <= w_pc_plus4;
        r_skid_vld    <= 1'b0;
        r_id_vld      <= w_cap_vld;
        r_id_pc       <= w_cap_pc;
        r_id_pc_plus4 <= w_cap_pc_plus4;
        r_id_instr    <= w_cap_vld ? w_cap_instr : NOP_INSTR;
      end
    end
  end

  assign bus.imem_req_o    = w_issue;
  assign bus.imem_addr_o   = r_pc;
  assign bus.id_valid_o    = r_id_vld;
  assign bus.id_pc_o       = r_id_pc;
  assign bus.id_pc_plus4_o = r_id_pc_plus4;
  assign bus.id_instr_o    = r_id_instr;
  assign bus.misalign_o    = r_misalign;

  // No issue happens while stalled, so the skid can never be asked to hold two entries.
  a_skid_single: assert property (@(posedge clk) disable iff (rst)
    !(bus.stall_i && !bus.redirect_i && r_resp_vld && r_skid_vld));

  a_pc_aligned: assert property (@(posedge clk) disable iff (rst) r_pc[1:0] == 2'b00);

endmodule
